// File: rtl/four_req_rr_arbiter.sv
// Four-requester arbiter with registered one-hot/encoded grant, round-robin or
// fixed priority selection, and a hold limit that forces release after HOLD_MAX cycles.
module four_req_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter bit RR_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  state_t        state;
  logic [CW-1:0] hold_cnt;
  logic [1:0]    ptr;
  logic [1:0]    winner;
  logic [1:0]    cand;

  // Later loop iterations overwrite earlier ones, so iteration order sets priority.
  always_comb begin
    winner = 2'd0;
    cand   = 2'd0;
    if (RR_EN) begin
      for (int i = 4; i >= 1; i--) begin
        cand = ptr + 2'(i);
        if (req[cand]) winner = cand;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req[i]) winner = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 4'b0000;
      grant_idx <= 2'd0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      ptr       <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          timeout  <= 1'b0;
          hold_cnt <= '0;
          if (req != 4'b0000) begin
            state     <= GRANT;
            grant     <= 4'b0001 << winner;
            grant_idx <= winner;
            busy      <= 1'b1;
          end
        end
        GRANT: begin
          // A requester still asserting at the exit edge means the hold limit forced it out.
          if (!req[grant_idx] || hold_cnt == HOLD_LAST) begin
            state     <= IDLE;
            grant     <= 4'b0000;
            grant_idx <= 2'd0;
            busy      <= 1'b0;
            ptr       <= grant_idx;
            hold_cnt  <= '0;
            timeout   <= req[grant_idx];
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_four_req_rr_arbiter.sv
// Directed bench for four_req_rr_arbiter: one round-robin and one fixed-priority
// instance sharing clock and reset, checked with immediate assertions.
module tb_four_req_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] reqRr = 4'b0000;
  logic [3:0] reqFp = 4'b0000;

  logic [3:0] grantRr, grantFp;
  logic [1:0] idxRr, idxFp;
  logic       busyRr, busyFp, timeoutRr, timeoutFp;

  logic [7:0] rrObs, fpObs;
  assign rrObs = {grantRr, idxRr, busyRr, timeoutRr};
  assign fpObs = {grantFp, idxFp, busyFp, timeoutFp};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  four_req_rr_arbiter #(.HOLD_MAX(8), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req(reqRr),
    .grant(grantRr), .grant_idx(idxRr), .busy(busyRr), .timeout(timeoutRr)
  );

  four_req_rr_arbiter #(.HOLD_MAX(8), .RR_EN(1'b0)) dutFp (
    .clk(clk), .rst(rst), .req(reqFp),
    .grant(grantFp), .grant_idx(idxFp), .busy(busyFp), .timeout(timeoutFp)
  );

  // Drive both request buses at a falling edge, then advance to the next falling edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] rf);
    reqRr = r;
    reqFp = rf;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [3:0] eGrant, input logic [1:0] eIdx,
                             input logic eTimeout);
    logic [7:0] exp;
    exp = {eGrant, eIdx, |eGrant, eTimeout};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed grant/idx/busy/timeout=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] g;

    // Reset and idle
    @(negedge clk);
    checkOutput("rst rr", rrObs, 4'b0000, 2'd0, 1'b0);
    checkOutput("rst fp", fpObs, 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("idle rr", rrObs, 4'b0000, 2'd0, 1'b0);
      checkOutput("idle fp", fpObs, 4'b0000, 2'd0, 1'b0);
    end

    // Round-robin rotation with forced releases
    applyStimulus(4'b1111, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      g = 4'(1 << k);
      for (int c = 0; c < 8; c++) begin
        checkOutput("rr hold", rrObs, g, k[1:0], 1'b0);
        applyStimulus(4'b1111, 4'b0000);
      end
      checkOutput("rr gap", rrObs, 4'b0000, 2'd0, 1'b1);
      applyStimulus(4'b1111, 4'b0000);
    end
    checkOutput("rr wrap", rrObs, 4'b0001, 2'd0, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("rr release", rrObs, 4'b0000, 2'd0, 1'b0);

    // Single short request
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("short c1", rrObs, 4'b0100, 2'd2, 1'b0);
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("short c2", rrObs, 4'b0100, 2'd2, 1'b0);
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("short c3", rrObs, 4'b0100, 2'd2, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("short drop", rrObs, 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("short idle", rrObs, 4'b0000, 2'd0, 1'b0);

    // Asynchronous reset in the middle of a grant
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("pre rst", rrObs, 4'b0010, 2'd1, 1'b0);
    #2 rst = 1'b1;
    #1 checkOutput("async rst", rrObs, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b1111, 4'b0000);
    checkOutput("post rst", rrObs, 4'b0001, 2'd0, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("post rst drop", rrObs, 4'b0000, 2'd0, 1'b0);

    // Release coinciding with the last allowed hold cycle is a normal release
    applyStimulus(4'b0010, 4'b0000);
    for (int c = 0; c < 7; c++) begin
      checkOutput("edge hold", rrObs, 4'b0010, 2'd1, 1'b0);
      applyStimulus(4'b0010, 4'b0000);
    end
    checkOutput("edge hold last", rrObs, 4'b0010, 2'd1, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("edge no timeout", rrObs, 4'b0000, 2'd0, 1'b0);

    // Held request is forced out after exactly 8 cycles, then re-granted
    applyStimulus(4'b0010, 4'b0000);
    for (int c = 0; c < 8; c++) begin
      checkOutput("forced hold", rrObs, 4'b0010, 2'd1, 1'b0);
      applyStimulus(4'b0010, 4'b0000);
    end
    checkOutput("forced timeout", rrObs, 4'b0000, 2'd0, 1'b1);
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("regrant", rrObs, 4'b0010, 2'd1, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("regrant drop", rrObs, 4'b0000, 2'd0, 1'b0);

    // Fixed priority: req[2] always beats req[0]
    applyStimulus(4'b0000, 4'b0101);
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 8; c++) begin
        checkOutput("fp hold", fpObs, 4'b0100, 2'd2, 1'b0);
        applyStimulus(4'b0000, 4'b0101);
      end
      checkOutput("fp gap", fpObs, 4'b0000, 2'd0, 1'b1);
      applyStimulus(4'b0000, 4'b0101);
    end
    checkOutput("fp third", fpObs, 4'b0100, 2'd2, 1'b0);
    applyStimulus(4'b0000, 4'b0001);
    checkOutput("fp release", fpObs, 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0000, 4'b0001);
    checkOutput("fp low", fpObs, 4'b0001, 2'd0, 1'b0);
    checkOutput("rr quiet", rrObs, 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("fp done", fpObs, 4'b0000, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
